voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 123 ++++++++++++
 tb/tb_voice_allocator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: 16-voice polyphonic note allocator with LRU stealing.
//   clk, rst_n   : clock, asynchronous active-low reset
//   note_valid/note_ready/note_on/note_num : note event handshake and payload
//   all_off      : synchronous panic, clears every gate and aborts any event
//   gate         : per-voice ADSR trigger
//   voice_note   : note held by voice i at [NOTE_W*i +: NOTE_W]
//   evt_valid/evt_voice/evt_kind : completion pulse, affected voice, event kind
module voice_allocator #(
    parameter int NOTE_W     = 7,
    parameter int NUM_VOICES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           note_valid,
    output logic                           note_ready,
    input  logic                           note_on,
    input  logic [NOTE_W-1:0]              note_num,
    input  logic                           all_off,
    output logic [NUM_VOICES-1:0]          gate,
    output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
    output logic                           evt_valid,
    output logic [3:0]                     evt_voice,
    output logic [1:0]                     evt_kind
);
    typedef enum logic [1:0] {IDLE, SCAN, APPLY, RETRIG} state_t;
    state_t              state;
    logic [3:0]          idx, free_v, match_v, old_v, tgt, tgt_c;
    logic                has_free, has_match, on_r;
    logic [NOTE_W-1:0]   note_r;
    logic [1:0]          kind_r, kind_c;
    logic [3:0]          age [NUM_VOICES];

    assign note_ready = (state == IDLE);
    assign tgt_c  = has_match ? match_v : has_free ? free_v : old_v;
    assign kind_c = has_match ? 2'b01 : has_free ? 2'b00 : 2'b10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            free_v     <= '0;
            match_v    <= '0;
            old_v      <= '0;
            tgt        <= '0;
            has_free   <= 1'b0;
            has_match  <= 1'b0;
            on_r       <= 1'b0;
            note_r     <= '0;
            kind_r     <= '0;
            gate       <= '0;
            voice_note <= '0;
            evt_valid  <= 1'b0;
            evt_voice  <= '0;
            evt_kind   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= 4'(i);
        end else begin
            evt_valid <= 1'b0;
            if (all_off) begin
                gate  <= '0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (note_valid) begin
                        on_r      <= note_on;
                        note_r    <= note_num;
                        idx       <= '0;
                        has_free  <= 1'b0;
                        has_match <= 1'b0;
                        state     <= SCAN;
                    end
                    SCAN: begin
                        if (!gate[idx] && !has_free) begin
                            has_free <= 1'b1;
                            free_v   <= idx;
                        end
                        if (gate[idx] && voice_note[NOTE_W*idx +: NOTE_W] == note_r && !has_match) begin
                            has_match <= 1'b1;
                            match_v   <= idx;
                        end
                        if (age[idx] == 4'd15) old_v <= idx;
                        idx <= idx + 4'd1;
                        if (idx == 4'd15) state <= APPLY;
                    end
                    APPLY: if (on_r) begin
                        voice_note[NOTE_W*tgt_c +: NOTE_W] <= note_r;
                        tgt    <= tgt_c;
                        kind_r <= kind_c;
                        // True LRU: younger voices age by one, target becomes newest
                        for (int i = 0; i < NUM_VOICES; i++)
                            age[i] <= (4'(i) == tgt_c) ? 4'd0 :
                                      (age[i] < age[tgt_c]) ? age[i] + 4'd1 : age[i];
                        if (!gate[tgt_c]) begin
                            gate[tgt_c] <= 1'b1;
                            evt_valid   <= 1'b1;
                            evt_voice   <= tgt_c;
                            evt_kind    <= kind_c;
                            state       <= IDLE;
                        end else begin
                            // Drop the gate for one cycle so the envelope sees a fresh attack
                            gate[tgt_c] <= 1'b0;
                            state       <= RETRIG;
                        end
                    end else begin
                        if (has_match) begin
                            gate[match_v] <= 1'b0;
                            evt_valid     <= 1'b1;
                            evt_voice     <= match_v;
                            evt_kind      <= 2'b11;
                        end
                        state <= IDLE;
                    end
                    RETRIG: begin
                        gate[tgt] <= 1'b1;
                        evt_valid <= 1'b1;
                        evt_voice <= tgt;
                        evt_kind  <= kind_r;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench for voice_allocator.
module tb_voice_allocator;
    localparam int NW = 7;
    logic clk = 1'b0, rst_n = 1'b0, note_valid = 1'b0, note_on = 1'b0, all_off = 1'b0;
    logic [NW-1:0] note_num = '0;
    logic note_ready, evt_valid;
    logic [15:0] gate;
    logic [16*NW-1:0] voice_note;
    logic [3:0] evt_voice;
    logic [1:0] evt_kind;
    int checks = 0, failures = 0;

    typedef struct {logic [3:0] v; logic [1:0] k;} exp_t;
    exp_t q[$];
    exp_t mon_e;

    logic [15:0] m_gate;
    logic [16*NW-1:0] m_vn;
    int m_age[16];

    always #5 clk = ~clk;

    voice_allocator #(.NOTE_W(NW), .NUM_VOICES(16)) dut (
        .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
        .note_on(note_on), .note_num(note_num), .all_off(all_off), .gate(gate),
        .voice_note(voice_note), .evt_valid(evt_valid), .evt_voice(evt_voice), .evt_kind(evt_kind)
    );

    always @(negedge clk) if (rst_n && evt_valid) begin
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL evt_unexpected got voice=%0d kind=%0d expected no event", evt_voice, evt_kind);
        end else begin
            mon_e = q.pop_front();
            if (evt_voice !== mon_e.v || evt_kind !== mon_e.k) begin
                failures++;
                $display("FAIL evt_payload got voice=%0d kind=%0d expected voice=%0d kind=%0d",
                         evt_voice, evt_kind, mon_e.v, mon_e.k);
            end
        end
    end

    function automatic void m_reset();
        m_gate = '0;
        m_vn   = '0;
        for (int i = 0; i < 16; i++) m_age[i] = i;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; note_valid = 1'b0; all_off = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic send(input bit on, input int num);
        int match = -1, free = -1, old = -1, tgt = 0, kind = 0, lat = 17, ta, hit = 0, n = 0;
        bit ev = 1'b0;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (m_gate[i] && m_vn[NW*i +: NW] == NW'(num) && match < 0) match = i;
            if (!m_gate[i] && free < 0) free = i;
            if (m_age[i] == 15) old = i;
        end
        if (on) begin
            tgt  = match >= 0 ? match : free >= 0 ? free : old;
            kind = match >= 0 ? 1 : free >= 0 ? 0 : 2;
            lat  = m_gate[tgt] ? 18 : 17;
            ta   = m_age[tgt];
            for (int i = 0; i < 16; i++) if (m_age[i] < ta) m_age[i]++;
            m_age[tgt] = 0;
            m_gate[tgt] = 1'b1;
            m_vn[NW*tgt +: NW] = NW'(num);
            ev = 1'b1;
        end else if (match >= 0) begin
            tgt = match; kind = 3; m_gate[tgt] = 1'b0; ev = 1'b1;
        end
        if (ev) begin
            e.v = 4'(tgt); e.k = 2'(kind);
            q.push_back(e);
        end
        @(negedge clk);
        while (!note_ready && n < 40) begin @(negedge clk); n++; end
        note_valid = 1'b1; note_on = on; note_num = NW'(num);
        @(posedge clk);
        #1 note_valid = 1'b0; note_on = ~on; note_num = ~note_num;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 17 && lat == 18) begin
                checks++;
                if (gate[tgt] !== 1'b0) begin
                    failures++;
                    $display("FAIL retrig_gate_low got %b expected 0 (voice %0d)", gate[tgt], tgt);
                end
            end
            if (!ev && k == 16) begin
                checks++;
                if (note_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL off_miss_busy got ready=%b expected 0 at t16", note_ready);
                end
            end
            if (!ev && k == 17) begin
                checks++;
                if (note_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL off_miss_ready got ready=%b expected 1 at t17", note_ready);
                end
            end
            if (evt_valid && hit == 0) hit = k;
            if (hit != 0) break;
        end
        checks++;
        if (hit != (ev ? lat : 0)) begin
            failures++;
            $display("FAIL latency note=%0d on=%0d got %0d expected %0d", num, on, hit, ev ? lat : 0);
        end
        checks++;
        if (gate !== m_gate) begin
            failures++;
            $display("FAIL gate got %h expected %h", gate, m_gate);
        end
        checks++;
        if (voice_note !== m_vn) begin
            failures++;
            $display("FAIL voice_note got %h expected %h", voice_note, m_vn);
        end
        if (ev) begin
            checks++;
            if (note_ready !== 1'b1) begin
                failures++;
                $display("FAIL ready_with_evt got %b expected 1", note_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (evt_valid !== 1'b0 || evt_voice !== 4'(tgt) || evt_kind !== 2'(kind)) begin
                failures++;
                $display("FAIL evt_hold got valid=%b voice=%0d kind=%0d expected valid=0 voice=%0d kind=%0d",
                         evt_valid, evt_voice, evt_kind, tgt, kind);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (gate !== 16'h0 || voice_note !== '0) begin
            failures++;
            $display("FAIL reset_voices got gate=%h notes=%h expected 0", gate, voice_note);
        end
        checks++;
        if (evt_valid !== 1'b0 || evt_voice !== 4'd0 || evt_kind !== 2'd0) begin
            failures++;
            $display("FAIL reset_evt got %b/%0d/%0d expected 0/0/0", evt_valid, evt_voice, evt_kind);
        end
        checks++;
        if (note_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b expected 1", note_ready);
        end
    endtask

    task automatic test_new();     send(1, 60); endtask
    task automatic test_retrig();  send(1, 60); endtask
    task automatic test_off();     send(0, 60); send(0, 61); endtask

    task automatic test_steal();
        do_reset();
        for (int n = 0; n < 16; n++) send(1, n);
        send(1, 99);
    endtask

    task automatic test_back_to_back();
        send(1, 5);
        send(0, 7);
        send(1, 7);
        send(1, 100);
        send(1, 101);
        send(0, 99);
        send(1, 42);
    endtask

    task automatic test_all_off();
        @(negedge clk);
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd70;
        @(posedge clk);
        #1 note_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        all_off = 1'b1; note_valid = 1'b1; note_on = 1'b1; note_num = 7'd80;
        m_gate = '0;
        @(posedge clk);
        #1;
        checks++;
        if (gate !== 16'h0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL all_off_gate got gate=%h evt=%b expected 0/0", gate, evt_valid);
        end
        checks++;
        if (note_ready !== 1'b1) begin
            failures++;
            $display("FAIL all_off_ready got %b expected 1", note_ready);
        end
        checks++;
        if (voice_note !== m_vn) begin
            failures++;
            $display("FAIL all_off_notes got %h expected %h", voice_note, m_vn);
        end
        @(posedge clk);
        #1;
        checks++;
        if (note_ready !== 1'b1) begin
            failures++;
            $display("FAIL all_off_no_accept got ready=%b expected 1", note_ready);
        end
        @(negedge clk);
        all_off = 1'b0; note_valid = 1'b0;
        repeat (20) @(posedge clk);
        send(1, 70);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        note_valid = 1'b1; note_on = 1'b1; note_num = 7'd50;
        @(posedge clk);
        #1 note_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gate !== 16'h0 || voice_note !== '0 || note_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async got gate=%h notes=%h ready=%b expected 0/0/1", gate, voice_note, note_ready);
        end
        checks++;
        if (evt_valid !== 1'b0 || evt_voice !== 4'd0 || evt_kind !== 2'd0) begin
            failures++;
            $display("FAIL reset_async_evt got %b/%0d/%0d expected 0/0/0", evt_valid, evt_voice, evt_kind);
        end
        #1 rst_n = 1'b1;
        m_reset();
        send(1, 60);
    endtask

    initial begin
        m_reset();
        do_reset();
        test_reset();
        test_new();
        test_retrig();
        test_off();
        test_steal();
        test_back_to_back();
        test_all_off();
        test_reset_mid();
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
